// File: rtl/hpf_trigger_readout_scheduler_if.sv
// Readout handshake between the trigger scheduler and its event consumer.
// The scheduler holds the event stable until rd_valid & rd_ready.
interface hpf_trigger_readout_scheduler_if;
    logic        rd_valid;
    logic        rd_ready;
    logic [5:0]  rd_channel;
    logic [31:0] rd_timestamp;

    modport master (
        output rd_valid,
        output rd_channel,
        output rd_timestamp,
        input  rd_ready
    );

    modport slave (
        input  rd_valid,
        input  rd_channel,
        input  rd_timestamp,
        output rd_ready
    );
endinterface

// File: rtl/hpf_trigger_readout_scheduler.sv
// Captures rising self-triggers per channel with timestamp and dead time,
// then reads pending channels out round-robin over a valid/ready port.
module hpf_trigger_readout_scheduler #(
    parameter int NCH       = 40,
    parameter int HOLDOFF_W = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [NCH-1:0]       chan_mask,
    input  logic [HOLDOFF_W-1:0] holdoff,
    input  logic [NCH-1:0]       trigger_in,
    hpf_trigger_readout_scheduler_if.master rd,
    output logic [NCH-1:0]       pending,
    output logic [15:0]          missed_count
);
    localparam int CH_W = 6;

    typedef enum logic {IDLE, PRESENT} state_t;

    state_t                 state_q, state_d;
    logic [31:0]            ts_cnt;
    logic [NCH-1:0]         trig_d;
    logic [NCH-1:0]         rise, armed, blocked, cap, clr;
    logic [HOLDOFF_W-1:0]   holdoff_cnt [NCH];
    logic [31:0]            ts_mem [NCH];
    logic [CH_W-1:0]        rr_ptr, sel, chan_q;
    logic [31:0]            stamp_q;
    logic                   sel_found, load, accept;
    int                     scan;

    // A channel is blocked while it is still queued or inside its dead time.
    always_comb begin
        rise  = trigger_in & ~trig_d;
        armed = rise & chan_mask & {NCH{enable}};
        for (int i = 0; i < NCH; i++) begin
            blocked[i] = pending[i] | (holdoff_cnt[i] != '0);
        end
        cap = armed & ~blocked;
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        sel       = '0;
        sel_found = 1'b0;
        scan      = 0;
        for (int k = 0; k < NCH; k++) begin
            scan = int'(rr_ptr) + k;
            if (scan >= NCH) scan = scan - NCH;
            if (!sel_found && pending[CH_W'(scan)]) begin
                sel_found = 1'b1;
                sel       = CH_W'(scan);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    load    = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (rd.rd_ready) begin
                    accept  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        clr = accept ? (NCH'(1) << chan_q) : '0;
    end

    assign rd.rd_valid     = (state_q == PRESENT);
    assign rd.rd_channel   = chan_q;
    assign rd.rd_timestamp = stamp_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            ts_cnt       <= '0;
            trig_d       <= '1;
            pending      <= '0;
            missed_count <= '0;
            rr_ptr       <= '0;
            chan_q       <= '0;
            stamp_q      <= '0;
            for (int i = 0; i < NCH; i++) holdoff_cnt[i] <= '0;
        end else begin
            state_q <= state_d;
            ts_cnt  <= ts_cnt + 32'd1;
            trig_d  <= trigger_in;
            pending <= (pending & ~clr) | cap;
            if (|(armed & blocked) && (missed_count != 16'hFFFF))
                missed_count <= missed_count + 16'd1;
            if (load) begin
                chan_q  <= sel;
                stamp_q <= ts_mem[sel];
            end
            if (accept)
                rr_ptr <= (chan_q == CH_W'(NCH - 1)) ? '0 : chan_q + CH_W'(1);
            for (int i = 0; i < NCH; i++) begin
                if (cap[i])
                    holdoff_cnt[i] <= holdoff;
                else if (holdoff_cnt[i] != '0)
                    holdoff_cnt[i] <= holdoff_cnt[i] - HOLDOFF_W'(1);
            end
        end
    end

    // NOTE: the timestamp store has no reset; an entry is only read after its pending bit was set by a write.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (cap[i]) ts_mem[i] <= ts_cnt;
        end
    end
endmodule

// File: tb/tb_hpf_trigger_readout_scheduler.sv
// Randomized and directed bench for the trigger readout scheduler with a
// behavioural model feeding an expected-event queue checked by a monitor.
module tb_hpf_trigger_readout_scheduler;
    localparam int NCH = 40;
    localparam int HW  = 12;

    logic            clk = 1'b0;
    logic            reset;
    logic            enable;
    logic [NCH-1:0]  chan_mask;
    logic [HW-1:0]   holdoff;
    logic [NCH-1:0]  trigger_in;
    logic [NCH-1:0]  pending;
    logic [15:0]     missed_count;

    hpf_trigger_readout_scheduler_if rd_if();

    hpf_trigger_readout_scheduler #(.NCH(NCH), .HOLDOFF_W(HW)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .chan_mask    (chan_mask),
        .holdoff      (holdoff),
        .trigger_in   (trigger_in),
        .rd           (rd_if),
        .pending      (pending),
        .missed_count (missed_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ch;
        logic [31:0] ts;
    } ev_t;

    ev_t exp_q[$];
    int  n_total = 0;
    int  n_bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per-channel queued flag, stored stamp and remaining dead time.
    bit          m_pend [NCH];
    bit          m_next [NCH];
    bit          m_prev [NCH];
    logic [31:0] m_stamp [NCH];
    int          m_dead [NCH];
    logic [31:0] m_time;
    int          m_missed;
    bit          m_offer;
    int          m_offer_ch;
    int          m_ptr;
    bit          m_any_miss;
    bit          m_armed;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                m_pend[i] = 0; m_prev[i] = 1; m_dead[i] = 0; m_stamp[i] = '0;
            end
            m_time = '0; m_missed = 0; m_offer = 0; m_offer_ch = 0; m_ptr = 0;
            exp_q.delete();
        end else begin
            m_any_miss = 0;
            for (int i = 0; i < NCH; i++) m_next[i] = m_pend[i];
            for (int i = 0; i < NCH; i++) begin
                m_armed = trigger_in[i] && !m_prev[i] && enable && chan_mask[i];
                if (m_armed && (m_pend[i] || m_dead[i] > 0)) m_any_miss = 1;
                if (m_armed && !m_pend[i] && m_dead[i] == 0) begin
                    m_next[i]  = 1;
                    m_stamp[i] = m_time;
                    m_dead[i]  = int'(holdoff);
                end else if (m_dead[i] > 0) begin
                    m_dead[i]--;
                end
                m_prev[i] = trigger_in[i];
            end
            if (m_offer) begin
                if (rd_if.rd_ready) begin
                    m_next[m_offer_ch] = 0;
                    m_ptr   = (m_offer_ch + 1) % NCH;
                    m_offer = 0;
                end
            end else begin
                for (int k = 0; k < NCH; k++) begin
                    if (!m_offer && m_pend[(m_ptr + k) % NCH]) begin
                        m_offer    = 1;
                        m_offer_ch = (m_ptr + k) % NCH;
                        exp_q.push_back('{ch: m_offer_ch, ts: m_stamp[m_offer_ch]});
                    end
                end
            end
            if (m_any_miss && m_missed < 65535) m_missed++;
            m_time = m_time + 32'd1;
            for (int i = 0; i < NCH; i++) m_pend[i] = m_next[i];
        end
    end

    function automatic logic [NCH-1:0] model_pending();
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = m_pend[i];
        return v;
    endfunction

    // Monitor: pops an expected event whenever a new one is presented.
    bit  prev_valid = 0;
    ev_t cur;

    always @(negedge clk) begin
        if (reset) begin
            prev_valid = 0;
        end else begin
            check("rd_valid", rd_if.rd_valid, m_offer);
            check("pending", pending, model_pending());
            check("missed_count", missed_count, m_missed);
            if (rd_if.rd_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    n_bad++;
                    $display("FAIL unexpected_event: got ch %0d with no expected event", rd_if.rd_channel);
                end else begin
                    cur = exp_q.pop_front();
                    check("rd_channel", rd_if.rd_channel, cur.ch);
                    check("rd_timestamp", rd_if.rd_timestamp, cur.ts);
                end
            end else if (rd_if.rd_valid && prev_valid) begin
                check("hold_channel", rd_if.rd_channel, cur.ch);
                check("hold_timestamp", rd_if.rd_timestamp, cur.ts);
            end
            prev_valid = rd_if.rd_valid;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [NCH-1:0] bits);
        trigger_in = bits;
        tick(1);
        trigger_in = '0;
    endtask

    function automatic logic [NCH-1:0] bit_of(input int ch);
        return NCH'(1) << ch;
    endfunction

    initial begin
        reset = 1'b1; enable = 1'b1; chan_mask = '1; holdoff = '0;
        trigger_in = '0; rd_if.rd_ready = 1'b0;
        tick(3);
        reset = 1'b0;
        check("rst_rd_valid", rd_if.rd_valid, 0);
        check("rst_rd_channel", rd_if.rd_channel, 0);
        check("rst_rd_timestamp", rd_if.rd_timestamp, 0);
        check("rst_pending", pending, 0);
        check("rst_missed", missed_count, 0);
        tick(2);

        // Single event with readout.
        holdoff = 12'd4; rd_if.rd_ready = 1'b1;
        pulse(bit_of(5));
        tick(6);
        check("single_pending5_clear", pending[5], 0);

        // Round-robin ordering and pointer wrap.
        pulse(bit_of(3) | bit_of(17) | bit_of(39));
        tick(10);
        pulse(bit_of(0) | bit_of(4));
        tick(8);

        // Backpressure then a second rise on the presented channel.
        rd_if.rd_ready = 1'b0;
        pulse(bit_of(7));
        tick(10);
        holdoff = '0;
        pulse(bit_of(7));
        tick(2);
        check("backpressure_missed", missed_count, 1);
        rd_if.rd_ready = 1'b1;
        tick(4);

        // Dead time: rises at relative cycles 0, 4, 12.
        holdoff = 12'd8;
        pulse(bit_of(2));
        tick(3);
        pulse(bit_of(2));
        tick(7);
        pulse(bit_of(2));
        tick(6);
        check("holdoff_missed", missed_count, 2);

        // Masked channel and drain with capture inhibited.
        holdoff = '0;
        chan_mask = ~bit_of(9);
        pulse(bit_of(9));
        tick(4);
        check("masked_missed", missed_count, 2);
        check("masked_pending", pending, 0);
        chan_mask = '1; rd_if.rd_ready = 1'b0;
        pulse(bit_of(1) | bit_of(6));
        tick(3);
        enable = 1'b0; chan_mask = '0;
        tick(1);
        rd_if.rd_ready = 1'b1;
        tick(8);
        check("disabled_drain", pending, 0);

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            if (c % 50 == 0) holdoff = HW'($urandom_range(0, 20));
            enable = ($urandom_range(0, 7) != 0);
            chan_mask = {$urandom, $urandom} | {$urandom, $urandom};
            rd_if.rd_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NCH; i++) trigger_in[i] = ($urandom_range(0, 5) == 0);
            tick(1);
        end
        trigger_in = '0; enable = 1'b0; rd_if.rd_ready = 1'b1;
        tick(150);
        check("random_queue_drained", exp_q.size(), 0);
        check("random_pending_drained", pending, 0);

        // Saturation: alternate rises on two queued channels every cycle.
        enable = 1'b1; chan_mask = '1; holdoff = '0; rd_if.rd_ready = 1'b0;
        pulse(bit_of(10));
        tick(3);
        pulse(bit_of(11));
        for (int c = 0; c < 66000; c++) begin
            trigger_in[10] = c[0];
            trigger_in[11] = ~c[0];
            tick(1);
        end
        trigger_in = '0;
        tick(2);
        check("saturated_missed", missed_count, 16'hFFFF);

        // Asynchronous reset while an event is presented.
        check("presenting_before_reset", rd_if.rd_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_rd_valid", rd_if.rd_valid, 0);
        check("async_rst_pending", pending, 0);
        check("async_rst_missed", missed_count, 0);
        tick(2);
        reset = 1'b0;
        tick(2);
        check("post_reset_idle", rd_if.rd_valid, 0);
        rd_if.rd_ready = 1'b1;
        pulse(bit_of(20));
        tick(6);
        check("final_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
